// File: rtl/snn_io_ctrl_if.sv
// Handshake/bus bundle between snn_io_ctrl and its neighbours: uart_rx byte
// strobe, input-RAM write port, SNN core start/done and uart_tx request.
//
// Handshake semantics (all synchronous to the controller clock):
//   rx_rdy     one-cycle strobe; rx_data is valid in that cycle only, with no backpressure.
//   ram_we     one write per cycle; ram_addr and ram_din are valid whenever ram_we=1.
//   core_start one-cycle request; the core replies with a one-cycle core_done,
//              and core_digit is valid in that cycle.
//   tx_start   one-cycle request, issued only while tx_rdy=1 (transmitter idle);
//              tx_data is held stable until the next classification.
interface snn_io_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_din;
    logic              core_start;
    logic              core_done;
    logic [3:0]        core_digit;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_rdy;

    modport master (
        input  rx_rdy, rx_data, core_done, core_digit, tx_rdy,
        output ram_we, ram_addr, ram_din, core_start, tx_start, tx_data
    );

    modport slave (
        output rx_rdy, rx_data, core_done, core_digit, tx_rdy,
        input  ram_we, ram_addr, ram_din, core_start, tx_start, tx_data
    );
endinterface

// File: rtl/snn_io_ctrl.sv
// Sample sequencer: unpacks UART bytes LSB-first into the 1-bit input RAM,
// kicks the SNN core, then reports the digit over UART and on the LEDs.
module snn_io_ctrl #(
    parameter int NUM_BYTES = 98,
    parameter int ADDR_W    = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    snn_io_ctrl_if.master     bus,
    output logic [7:0]        o_led,
    output logic              o_busy,
    output logic              o_overrun,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        UNPACK    = 3'd1,
        START     = 3'd2,
        WAIT_CORE = 3'd3,
        TX        = 3'd4,
        TX_BUSY   = 3'd5,
        TX_DONE   = 3'd6
    } state_t;

    localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

    state_t            r_state;
    logic [7:0]        r_shift;
    logic [6:0]        r_byte_cnt;
    logic [2:0]        r_bit_cnt;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_din;
    logic              r_core_start;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    logic [7:0]        r_led;
    logic              r_overrun;

    state_t            w_state_nxt;
    logic [7:0]        w_shift_nxt;
    logic [6:0]        w_byte_cnt_nxt;
    logic [2:0]        w_bit_cnt_nxt;
    logic              w_ram_we_nxt;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic              w_ram_din_nxt;
    logic              w_core_start_nxt;
    logic              w_tx_start_nxt;
    logic [7:0]        w_tx_data_nxt;
    logic [7:0]        w_led_nxt;
    logic              w_overrun_nxt;
    logic [9:0]        w_addr_full;

    // Byte i, bit j maps to address 8i+j; the last-byte check precedes the
    // increment, so the concatenation never wraps.
    assign w_addr_full = {r_byte_cnt, r_bit_cnt};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= LOAD;
            r_shift      <= 8'h00;
            r_byte_cnt   <= 7'd0;
            r_bit_cnt    <= 3'd0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= 1'b0;
            r_core_start <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_led        <= 8'h00;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_ram_we     <= w_ram_we_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_din    <= w_ram_din_nxt;
            r_core_start <= w_core_start_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_led        <= w_led_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    // Outputs are registered, so each strobe appears one cycle after the
    // state that requests it.
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_ram_we_nxt     = 1'b0;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_din_nxt    = r_ram_din;
        w_core_start_nxt = 1'b0;
        w_tx_start_nxt   = 1'b0;
        w_tx_data_nxt    = r_tx_data;
        w_led_nxt        = r_led;
        w_overrun_nxt    = r_overrun | (bus.rx_rdy && (r_state != LOAD));

        case (r_state)
            LOAD: begin
                if (bus.rx_rdy) begin
                    w_shift_nxt   = bus.rx_data;
                    w_bit_cnt_nxt = 3'd0;
                    w_state_nxt   = UNPACK;
                end
            end
            UNPACK: begin
                w_ram_we_nxt   = 1'b1;
                w_ram_addr_nxt = ADDR_W'(w_addr_full);
                w_ram_din_nxt  = r_shift[0];
                w_shift_nxt    = {1'b0, r_shift[7:1]};
                w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_byte_cnt_nxt = 7'd0;
                        w_state_nxt    = START;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 7'd1;
                        w_state_nxt    = LOAD;
                    end
                end
            end
            START: begin
                w_core_start_nxt = 1'b1;
                w_state_nxt      = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (bus.core_done) begin
                    w_led_nxt     = {4'h0, bus.core_digit};
                    w_tx_data_nxt = {4'h0, bus.core_digit};
                    w_state_nxt   = TX;
                end
            end
            TX: begin
                if (bus.tx_rdy) begin
                    w_tx_start_nxt = 1'b1;
                    w_state_nxt    = TX_BUSY;
                end
            end
            TX_BUSY: begin
                // Wait for the transmitter to acknowledge by dropping tx_rdy.
                if (!bus.tx_rdy) begin
                    w_state_nxt = TX_DONE;
                end
            end
            TX_DONE: begin
                if (bus.tx_rdy) begin
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    assign bus.ram_we     = r_ram_we;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_din    = r_ram_din;
    assign bus.core_start = r_core_start;
    assign bus.tx_start   = r_tx_start;
    assign bus.tx_data    = r_tx_data;

    assign o_led     = r_led;
    assign o_busy    = (r_state != LOAD);
    assign o_overrun = r_overrun;
    assign o_state   = r_state;

endmodule

// File: tb/tb_snn_io_ctrl.sv
// Directed bench for snn_io_ctrl: RAM unpack order, core/UART sequencing,
// overrun handling, mid-sample reset and back-to-back samples.
module tb_snn_io_ctrl;

    localparam int NUM_BYTES = 98;
    localparam int ADDR_W    = 10;
    localparam int NUM_BITS  = NUM_BYTES * 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led;
    logic       busy;
    logic       overrun;
    logic [2:0] state;

    snn_io_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    snn_io_ctrl #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus),
        .o_led     (led),
        .o_busy    (busy),
        .o_overrun (overrun),
        .o_state   (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected and observed RAM writes as {din, addr}.
    logic [ADDR_W:0] exp_q[$];
    logic [ADDR_W:0] obs_q[$];
    logic [7:0]      tx_q[$];
    int start_cnt   = 0;
    int start_cyc   = 0;
    int tx_cnt      = 0;
    int tx_cyc      = 0;
    int last_rx_cyc = 0;
    int done_cyc    = 0;

    always @(negedge clk) begin
        if (bus.ram_we) obs_q.push_back({bus.ram_din, bus.ram_addr});
        if (bus.core_start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (bus.tx_start) begin
            tx_cnt++;
            tx_cyc = cyc;
            tx_q.push_back(bus.tx_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] sample_byte(input int kind, input int i);
        case (kind)
            0:       return 8'hA5;
            1:       return 8'(i * 37 + 11);
            2:       return 8'(255 - i * 2);
            default: return 8'(i) ^ 8'h5A;
        endcase
    endfunction

    function automatic int wr_mismatches();
        int n = 0;
        int m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (obs_q[i] !== exp_q[i]) n++;
        n += (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                           : exp_q.size() - obs_q.size();
        return n;
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        tx_q.delete();
        start_cnt = 0;
        tx_cnt    = 0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        last_rx_cyc = cyc;
        @(posedge clk); #1;
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] b, input int idx);
        for (int j = 0; j < 8; j++) exp_q.push_back({b[j], ADDR_W'(idx * 8 + j)});
    endtask

    task automatic send_byte(input logic [7:0] b, input int idx);
        pulse_rx(b);
        push_exp(b, idx);
        repeat (8) @(posedge clk);
    endtask

    task automatic send_sample(input int kind, input int first);
        for (int i = first; i < NUM_BYTES; i++) send_byte(sample_byte(kind, i), i);
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_done(input logic [3:0] d);
        @(posedge clk); #1;
        bus.core_done  = 1'b1;
        bus.core_digit = d;
        done_cyc       = cyc;
        @(posedge clk); #1;
        bus.core_done  = 1'b0;
    endtask

    task automatic tx_ack();
        @(posedge clk); #1;
        bus.tx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.tx_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [27:0] outs;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {bus.ram_we, bus.ram_addr, bus.ram_din, bus.core_start, bus.tx_start,
                bus.tx_data, led[6:0]};
        total++;
        if ({outs, led[7], busy, overrun} !== 31'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h want 0", {outs, led[7], busy, overrun});
        end
        total++;
        if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, bus.ram_we, bus.core_start} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: got %b want 000", {busy, bus.ram_we, bus.core_start});
        end
    endtask

    task automatic test_full_load();
        logic [ADDR_W:0] last_wr;
        clear_sb();
        send_sample(0, 0);
        total++;
        if (wr_mismatches() !== 0) begin
            bad++;
            $display("FAIL a5_write_seq: got %0d bad entries (%0d writes) want 0", wr_mismatches(), obs_q.size());
        end
        total++;
        if (obs_q.size() !== NUM_BITS) begin
            bad++;
            $display("FAIL a5_write_count: got %0d want %0d", obs_q.size(), NUM_BITS);
        end
        last_wr = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 'x;
        total++;
        if (last_wr !== {1'b1, 10'd783}) begin
            bad++;
            $display("FAIL a5_last_write: got %0h want %0h", last_wr, {1'b1, 10'd783});
        end
        total++;
        if (start_cnt !== 1) begin bad++; $display("FAIL a5_start_count: got %0d want 1", start_cnt); end
        total++;
        if (start_cyc - last_rx_cyc !== 10) begin
            bad++;
            $display("FAIL start_latency: got %0d want 10", start_cyc - last_rx_cyc);
        end
        total++;
        if ({busy, overrun} !== 2'b10) begin
            bad++;
            $display("FAIL wait_core_flags: got %b want 10", {busy, overrun});
        end
    endtask

    task automatic test_core_tx();
        logic [7:0] got;
        pulse_done(4'h7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (led !== 8'h07) begin bad++; $display("FAIL led_7: got %0h want 07", led); end
        total++;
        if (tx_cnt !== 1) begin bad++; $display("FAIL tx_count_7: got %0d want 1", tx_cnt); end
        total++;
        if (tx_cyc - done_cyc !== 2) begin
            bad++;
            $display("FAIL tx_latency: got %0d want 2", tx_cyc - done_cyc);
        end
        got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
        total++;
        if (got !== 8'h07) begin bad++; $display("FAIL tx_data_7: got %0h want 07", got); end
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (state !== 3'd5) begin bad++; $display("FAIL hold_tx_busy: got state %0d want 5", state); end
        @(posedge clk); #1;
        bus.tx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL tx_done_busy: got %b want 1", busy); end
        #1;
        bus.tx_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, state} !== 4'b0000) begin
            bad++;
            $display("FAIL back_to_load: got busy/state %b want 0000", {busy, state});
        end
    endtask

    task automatic test_tx_stall();
        int rise_cyc;
        logic [7:0] got;
        clear_sb();
        bus.tx_rdy = 1'b0;
        send_sample(1, 0);
        total++;
        if (wr_mismatches() !== 0 || start_cnt !== 1) begin
            bad++;
            $display("FAIL stall_load: got %0d bad writes, %0d starts want 0, 1", wr_mismatches(), start_cnt);
        end
        pulse_done(4'h3);
        repeat (50) @(posedge clk);
        @(negedge clk);
        total++;
        if (tx_cnt !== 0) begin bad++; $display("FAIL stall_no_tx: got %0d want 0", tx_cnt); end
        total++;
        if ({led, state} !== {8'h03, 3'd4}) begin
            bad++;
            $display("FAIL stall_led_state: got %0h/%0d want 03/4", led, state);
        end
        @(posedge clk); #1;
        bus.tx_rdy = 1'b1;
        rise_cyc   = cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
        total++;
        if (tx_cnt !== 1 || got !== 8'h03) begin
            bad++;
            $display("FAIL stall_tx: got count %0d data %0h want 1 03", tx_cnt, got);
        end
        total++;
        if (tx_cyc - rise_cyc !== 1) begin
            bad++;
            $display("FAIL stall_tx_delay: got %0d want 1", tx_cyc - rise_cyc);
        end
        tx_ack();
    endtask

    task automatic test_overrun();
        logic [7:0] got;
        clear_sb();
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
        pulse_rx(sample_byte(2, 0));
        push_exp(sample_byte(2, 0), 0);
        pulse_rx(8'hFF);
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_unpack: got %b want 1", overrun); end
        send_sample(2, 1);
        total++;
        if (wr_mismatches() !== 0 || obs_q.size() !== NUM_BITS) begin
            bad++;
            $display("FAIL overrun_write_seq: got %0d bad, %0d writes want 0, %0d",
                     wr_mismatches(), obs_q.size(), NUM_BITS);
        end
        pulse_rx(8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({obs_q.size() == NUM_BITS, overrun, state} !== {1'b1, 1'b1, 3'd3}) begin
            bad++;
            $display("FAIL overrun_wait_core: got writes %0d ovr %b state %0d want %0d 1 3",
                     obs_q.size(), overrun, state, NUM_BITS);
        end
        pulse_done(4'h9);
        repeat (3) @(posedge clk);
        tx_ack();
        got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
        total++;
        if ({got, busy} !== {8'h09, 1'b0}) begin
            bad++;
            $display("FAIL overrun_tx: got %0h busy %b want 09 0", got, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W:0] first_wr;
        clear_sb();
        for (int i = 0; i < 40; i++) send_byte(sample_byte(3, i), i);
        pulse_rx(sample_byte(3, 40));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.ram_we, bus.ram_addr, bus.ram_din, bus.core_start, bus.tx_start, bus.tx_data,
             led, busy, overrun, state} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: we %b addr %0d led %0h ovr %b state %0d want all 0",
                     bus.ram_we, bus.ram_addr, led, overrun, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_sb();
        send_sample(3, 0);
        first_wr = (obs_q.size() > 0) ? obs_q[0] : 'x;
        total++;
        if (first_wr !== {sample_byte(3, 0) & 8'h01, 10'd0} >> 7) begin
            bad++;
            $display("FAIL post_reset_first_write: got %0h want addr 0", first_wr);
        end
        total++;
        if (wr_mismatches() !== 0 || start_cnt !== 1) begin
            bad++;
            $display("FAIL post_reset_sample: got %0d bad, %0d starts want 0, 1", wr_mismatches(), start_cnt);
        end
        pulse_done(4'h5);
        repeat (3) @(posedge clk);
        tx_ack();
        total++;
        if ({led, busy} !== {8'h05, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_led: got %0h busy %b want 05 0", led, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got0;
        logic [7:0] got1;
        clear_sb();
        send_sample(1, 0);
        pulse_done(4'h2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (led !== 8'h02) begin bad++; $display("FAIL b2b_led_2: got %0h want 02", led); end
        tx_ack();
        send_sample(2, 0);
        pulse_done(4'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (led !== 8'h00) begin bad++; $display("FAIL b2b_led_0: got %0h want 00", led); end
        tx_ack();
        got0 = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
        got1 = (tx_q.size() > 1) ? tx_q[1] : 8'hxx;
        total++;
        if ({tx_cnt == 2, got0, got1} !== {1'b1, 8'h02, 8'h00}) begin
            bad++;
            $display("FAIL b2b_tx: got count %0d data %0h %0h want 2 02 00", tx_cnt, got0, got1);
        end
        total++;
        if ({start_cnt == 2, wr_mismatches() == 0, busy} !== 3'b110) begin
            bad++;
            $display("FAIL b2b_samples: got starts %0d bad writes %0d busy %b want 2 0 0",
                     start_cnt, wr_mismatches(), busy);
        end
    endtask

    initial begin
        bus.rx_rdy     = 1'b0;
        bus.rx_data    = 8'h00;
        bus.core_done  = 1'b0;
        bus.core_digit = 4'h0;
        bus.tx_rdy     = 1'b1;
        test_reset();
        test_full_load();
        test_core_tx();
        test_tx_stall();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
